// File: rtl/soc_mmio_pkg.sv
// Constants and the byte-lane merge helper shared by the data SRAM responder and its MMIO bank.
package soc_mmio_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hbfaf;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH = 16'h000c;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_core.sv
// Single-port word RAM with per-byte write enables and a registered read-first output.
module sram_core #(
  parameter int unsigned RAM_AW = 14
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        wen_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**RAM_AW];
  logic [31:0] rdata_q;

  // No reset: keeps the array and its output register mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int i = 0; i < 4; i++) begin
        if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM port responder: decodes core accesses to on-chip RAM or the MMIO register bank,
// returning read data one cycle after the request.
module data_sram_responder
  import soc_mmio_pkg::*;
#(
  parameter int unsigned RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic        addr_err
);

  logic        is_mmio;
  logic [15:0] offset;
  logic        mmio_wr;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_cur;
  logic [31:0] mmio_merged;

  logic [15:0] sync1_q, sync2_q;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        sel_mmio_q, sel_mmio_d;
  logic        addr_err_q, addr_err_d;

  assign is_mmio = (data_sram_addr[31:16] == MMIO_HI);
  assign offset  = {data_sram_addr[15:2], 2'b00};
  assign mmio_wr = data_sram_en && is_mmio && (data_sram_wen != 4'h0);
  // An access in flight when reset asserts must not land in the array.
  assign ram_en  = data_sram_en && !is_mmio && resetn;

  sram_core #(
    .RAM_AW(RAM_AW)
  ) u_sram_core (
    .clk_i  (clk),
    .en_i   (ram_en),
    .wen_i  (data_sram_wen),
    .addr_i (data_sram_addr[RAM_AW+1:2]),
    .wdata_i(data_sram_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    mmio_cur = 32'h0;
    case (offset)
      OFF_LED:     mmio_cur = {16'h0, led_q};
      OFF_SWITCH:  mmio_cur = {16'h0, sync2_q};
      OFF_TIMER:   mmio_cur = timer_q;
      OFF_SCRATCH: mmio_cur = scratch_q;
      default:     mmio_cur = 32'h0;
    endcase
  end

  assign mmio_merged = byte_merge(mmio_cur, data_sram_wdata, data_sram_wen);

  always_comb begin
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    scratch_d    = scratch_q;
    mmio_rdata_d = mmio_rdata_q;
    sel_mmio_d   = sel_mmio_q;
    addr_err_d   = data_sram_en && (data_sram_addr[1:0] != 2'b00);

    if (data_sram_en) begin
      sel_mmio_d = is_mmio;
      if (is_mmio) mmio_rdata_d = mmio_cur;
    end

    if (mmio_wr) begin
      case (offset)
        OFF_LED:     led_d     = mmio_merged[15:0];
        // The load beat itself counts, so the loaded value is already one tick on.
        OFF_TIMER:   timer_d   = mmio_merged + 32'd1;
        OFF_SCRATCH: scratch_d = mmio_merged;
        default:     ;
      endcase
    end
  end

  // sel_mmio resets to 1 so rdata shows the zeroed MMIO read register out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= 16'h0;
      sync2_q      <= 16'h0;
      led_q        <= 16'h0;
      timer_q      <= 32'h0;
      scratch_q    <= 32'h0;
      mmio_rdata_q <= 32'h0;
      sel_mmio_q   <= 1'b1;
      addr_err_q   <= 1'b0;
    end else begin
      sync1_q      <= switch_in;
      sync2_q      <= sync1_q;
      led_q        <= led_d;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
      mmio_rdata_q <= mmio_rdata_d;
      sel_mmio_q   <= sel_mmio_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign data_sram_rdata = sel_mmio_q ? mmio_rdata_q : ram_rdata;
  assign led_out         = led_q;
  assign addr_err        = addr_err_q;

endmodule
